cmd_region_relay: RTL and testbench
===================================

Name: cmd_region_relay

Overview:
- Parametrised successor to the single-region command loopback.
- Fetches a command region of up to DEPTH words from an upstream mem_handle-style read port into a local buffer.
- Announces it downstream with cmd_send, then serves random-access reads until the consumer signals cmd_done.
- Adds: parametrised width and depth, a real upstream ptr with non-zero region_begin, an optional reversed-order mode, and length error detection.

Parameters:
DATA_W, 32, word width of in_data/out_data and buffer entries
DEPTH, 16, buffer capacity in words (power of two, >=2)
ADDR_W, 8, width of all region/ptr address fields

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
cmd_ready  in  1  upstream has a command region available (level)
mode_rev  in  1  sampled at acceptance; 1 = serve words in reversed order
in_region_begin  in  ADDR_W  first upstream word address (inclusive)
in_region_end  in  ADDR_W  last upstream word address (inclusive)
in_ptr  out  ADDR_W  upstream read address
in_r_en  out  1  upstream read request
in_done  in  1  upstream read complete; in_data valid this cycle
in_data  in  DATA_W  upstream read data
cmd_send  out  1  one-cycle pulse: buffered region ready downstream
out_region_begin  out  ADDR_W  constant 0
out_region_end  out  ADDR_W  len-1 of buffered region
out_r_en  in  1  downstream read request
out_ptr  in  ADDR_W  downstream read address (0-based)
out_done  out  1  one-cycle pulse: out_data valid
out_data  out  DATA_W  downstream read data
cmd_done  in  1  downstream finished with region
busy  out  1  high whenever state != IDLE
cmd_err  out  1  one-cycle pulse: rejected command

Behaviour:
- Reset (rst high at clk edge):
  - state=IDLE; in_ptr=0, in_r_en=0, cmd_send=0, out_region_end=0, out_done=0, out_data=0, busy=0, cmd_err=0.
  - Index and latched region cleared. Buffer contents need not be cleared.
  - Reset mid-operation aborts immediately; any upstream read in flight is abandoned.
- len = in_region_end - in_region_begin + 1, computed in ADDR_W+1 bits.
- States and transitions:
  - IDLE, cmd_ready=1:
    - If in_region_end < in_region_begin or len > DEPTH: pulse cmd_err next cycle, stay IDLE. cmd_ready must drop before the next command is accepted; a held level re-errors every cycle.
    - Otherwise: latch begin, len and mode_rev; index=0; in_ptr=begin; in_r_en=1 next cycle; go FETCH.
  - FETCH:
    - One outstanding read at a time. in_done is honoured only while in_r_en=1.
    - On in_r_en && in_done: buffer[index]=in_data, index+1, in_r_en=0.
    - One-cycle gap after each capture, then re-assert in_r_en with in_ptr=begin+index, if index<len.
    - When the last word is captured (index becomes len): next cycle pulse cmd_send, out_region_end=len-1, out_data=0, index=0, go SERVE.
    - in_done while in_r_en=0 is ignored.
  - SERVE, on out_r_en && !out_done:
    - Next cycle out_data is buffer[out_ptr] (mode_rev=0) or buffer[len-1-out_ptr] (mode_rev=1), and out_done pulses for one cycle.
    - If out_ptr >= len: out_data=0, out_done still pulses.
    - Read latency is 1 cycle. With out_r_en held high, out_done toggles 1,0,1,...
  - SERVE, on cmd_done: go IDLE next cycle.
    - cmd_done has priority over a same-cycle out_r_en; no out_done is produced for it.
    - out_region_end and out_data hold their values.
- cmd_ready is ignored outside IDLE.
- busy is combinational from state.
- Boundary cases:
  - len=1: a single read, then cmd_send.
  - len=DEPTH: fills the buffer exactly.
  - Address arithmetic: begin+index never wraps because end >= begin is enforced.

Test Plan:
- Reset, then begin=0x10, end=0x13, mode_rev=0, upstream done 2 cycles after each r_en with data 0xA0..0xA3 -> in_ptr 0x10..0x13 in order, one cmd_send, out_region_end=3; downstream reads ptr 0..3 return 0xA0..0xA3.
- Same region with mode_rev=1 -> out_ptr 0 returns 0xA3, out_ptr 3 returns 0xA0.
- begin=0, end=DEPTH-1 (15) -> 16 captures, out_region_end=15. Then begin=0, end=16 -> cmd_err pulse, busy stays 0, no in_r_en.
- end=0x05, begin=0x06 -> cmd_err pulse, no fetch. Then begin=end=0x20 -> a single read, cmd_send, out_region_end=0.
- In SERVE: out_ptr=7 with len=4 -> out_data=0, out_done=1. Then cmd_done and out_r_en in the same cycle -> no out_done, state IDLE next cycle.
- Assert rst during FETCH after 2 of 4 words -> all outputs at reset values next cycle. A fresh command then completes normally.

Source files
------------

// File: rtl/cmd_region_relay.sv
// Command region relay: fetches an upstream region of up to DEPTH words into a local
// buffer, announces it downstream, and serves random-access reads until released.
module cmd_region_relay #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ready,
  input  logic              mode_rev,
  input  logic [ADDR_W-1:0] in_region_begin,
  input  logic [ADDR_W-1:0] in_region_end,
  output logic [ADDR_W-1:0] in_ptr,
  output logic              in_r_en,
  input  logic              in_done,
  input  logic [DATA_W-1:0] in_data,
  output logic              cmd_send,
  output logic [ADDR_W-1:0] out_region_begin,
  output logic [ADDR_W-1:0] out_region_end,
  input  logic              out_r_en,
  input  logic [ADDR_W-1:0] out_ptr,
  output logic              out_done,
  output logic [DATA_W-1:0] out_data,
  input  logic              cmd_done,
  output logic              busy,
  output logic              cmd_err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, SERVE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   beg_q, beg_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic                rev_q, rev_d;
  logic [ADDR_W-1:0]   in_ptr_d;
  logic                in_r_en_d;
  logic                cmd_send_d;
  logic                out_done_d;
  logic                cmd_err_d;
  logic [ADDR_W-1:0]   out_region_end_d;
  logic [DATA_W-1:0]   out_data_d;

  logic [DATA_W-1:0]   buf_mem [DEPTH];

  logic [ADDR_W:0]     req_len;
  logic                req_bad;
  logic                capture;
  logic                rd_oob;
  logic [IW-1:0]       rd_idx;

  assign out_region_begin = '0;
  assign busy             = (state != IDLE);

  assign req_len = {1'b0, in_region_end} - {1'b0, in_region_begin} + ONE_L;
  assign req_bad = (in_region_end < in_region_begin) || (req_len > DEPTH_L);
  assign capture = (state == FETCH) && in_r_en && in_done;

  // Reversed mode mirrors the index around len-1; out-of-range pointers read as zero.
  assign rd_oob = ({1'b0, out_ptr} >= len_q);
  assign rd_idx = rev_q ? IW'(len_q - {1'b0, out_ptr} - ONE_L) : IW'(out_ptr);

  always_ff @(posedge clk) begin
    if (capture) buf_mem[IW'(idx_q)] <= in_data;
  end

  always_comb begin
    state_d          = state;
    beg_d            = beg_q;
    len_d            = len_q;
    idx_d            = idx_q;
    rev_d            = rev_q;
    in_ptr_d         = in_ptr;
    in_r_en_d        = in_r_en;
    cmd_send_d       = 1'b0;
    out_done_d       = 1'b0;
    cmd_err_d        = 1'b0;
    out_region_end_d = out_region_end;
    out_data_d       = out_data;

    case (state)
      IDLE: begin
        if (cmd_ready) begin
          if (req_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            beg_d     = in_region_begin;
            len_d     = req_len;
            rev_d     = mode_rev;
            idx_d     = '0;
            in_ptr_d  = in_region_begin;
            in_r_en_d = 1'b1;
            state_d   = FETCH;
          end
        end
      end
      FETCH: begin
        // The cycle with in_r_en low after each capture either re-requests or hands off.
        if (in_r_en) begin
          if (in_done) begin
            idx_d     = idx_q + ONE_L;
            in_r_en_d = 1'b0;
          end
        end else if (idx_q == len_q) begin
          cmd_send_d       = 1'b1;
          out_region_end_d = ADDR_W'(len_q - ONE_L);
          out_data_d       = '0;
          idx_d            = '0;
          state_d          = SERVE;
        end else begin
          in_r_en_d = 1'b1;
          in_ptr_d  = beg_q + ADDR_W'(idx_q);
        end
      end
      SERVE: begin
        if (cmd_done) begin
          state_d = IDLE;
        end else if (out_r_en && !out_done) begin
          out_done_d = 1'b1;
          out_data_d = rd_oob ? '0 : buf_mem[rd_idx];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beg_q          <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      rev_q          <= 1'b0;
      in_ptr         <= '0;
      in_r_en        <= 1'b0;
      cmd_send       <= 1'b0;
      out_done       <= 1'b0;
      cmd_err        <= 1'b0;
      out_region_end <= '0;
      out_data       <= '0;
    end else begin
      state          <= state_d;
      beg_q          <= beg_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      rev_q          <= rev_d;
      in_ptr         <= in_ptr_d;
      in_r_en        <= in_r_en_d;
      cmd_send       <= cmd_send_d;
      out_done       <= out_done_d;
      cmd_err        <= cmd_err_d;
      out_region_end <= out_region_end_d;
      out_data       <= out_data_d;
    end
  end

endmodule

// File: tb/tb_cmd_region_relay.sv
// Scoreboard bench for cmd_region_relay: stimulus pushes expected events, a monitor
// pops and compares them against a region-level reference model.
module tb_cmd_region_relay;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_ready = 1'b0;
  logic              mode_rev = 1'b0;
  logic [ADDR_W-1:0] in_region_begin = '0;
  logic [ADDR_W-1:0] in_region_end = '0;
  logic [ADDR_W-1:0] in_ptr;
  logic              in_r_en;
  logic              in_done = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              cmd_send;
  logic [ADDR_W-1:0] out_region_begin;
  logic [ADDR_W-1:0] out_region_end;
  logic              out_r_en = 1'b0;
  logic [ADDR_W-1:0] out_ptr = '0;
  logic              out_done;
  logic [DATA_W-1:0] out_data;
  logic              cmd_done = 1'b0;
  logic              busy;
  logic              cmd_err;

  cmd_region_relay #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .mode_rev(mode_rev),
    .in_region_begin(in_region_begin), .in_region_end(in_region_end),
    .in_ptr(in_ptr), .in_r_en(in_r_en), .in_done(in_done), .in_data(in_data),
    .cmd_send(cmd_send), .out_region_begin(out_region_begin),
    .out_region_end(out_region_end), .out_r_en(out_r_en), .out_ptr(out_ptr),
    .out_done(out_done), .out_data(out_data), .cmd_done(cmd_done),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] exp_ptr_q [$];
  logic [ADDR_W-1:0] exp_end_q [$];
  logic [DATA_W-1:0] exp_rd_q [$];
  int                exp_err = 0;
  logic [DATA_W-1:0] cur_region [$];
  bit                cur_rev = 1'b0;
  int                send_cnt = 0;
  int                req_cnt = 0;
  bit                noise = 1'b0;
  bit                rand_lat = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event value %0h expected no event", name, act);
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int p);
    int len = cur_region.size();
    if (p >= len) return '0;
    return cur_rev ? cur_region[len-1-p] : cur_region[p];
  endfunction

  // Monitor: compares every DUT-presented event against the scoreboard queues.
  initial begin
    logic prev_ren = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_r_en && !prev_ren) begin
          if (exp_ptr_q.size() == 0) unexpected("in_r_en", 64'(in_ptr));
          else chk("in_ptr", 64'(in_ptr), 64'(exp_ptr_q.pop_front()));
        end
        if (cmd_send) begin
          send_cnt++;
          if (exp_end_q.size() == 0) unexpected("cmd_send", 64'(out_region_end));
          else chk("out_region_end", 64'(out_region_end), 64'(exp_end_q.pop_front()));
          chk("out_region_begin", 64'(out_region_begin), 64'(0));
        end
        if (out_done) begin
          if (exp_rd_q.size() == 0) unexpected("out_done", 64'(out_data));
          else chk("out_data", 64'(out_data), 64'(exp_rd_q.pop_front()));
        end
        if (cmd_err) begin
          if (exp_err == 0) unexpected("cmd_err", 64'(1));
          else begin
            checks++;
            exp_err--;
          end
        end
      end
      prev_ren = rst ? 1'b0 : in_r_en;
    end
  end

  // Upstream memory responder, optionally with random latency and stray in_done pulses.
  initial begin
    int lat = 2;
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_done = 1'b0;
        cnt = 0;
      end else if (in_done) begin
        in_done = 1'b0;
      end else if (in_r_en) begin
        cnt++;
        if (cnt >= lat) begin
          in_done = 1'b1;
          in_data = mem[in_ptr];
          cnt = 0;
          req_cnt++;
          lat = rand_lat ? int'($urandom_range(1, 3)) : 2;
        end
      end else begin
        cnt = 0;
        if (noise && $urandom_range(0, 3) == 0) begin
          in_done = 1'b1;
          in_data = $urandom;
        end
      end
    end
  end

  task automatic wait_send(input int start);
    for (int k = 0; k < 400 && send_cnt == start; k++) @(negedge clk);
    checks++;
    if (send_cnt == start) begin
      errors++;
      $display("FAIL cmd_send_timeout: got no cmd_send expected one within 400 cycles");
    end
  endtask

  task automatic issue(input int b, input int e, input bit rev, input int hold);
    int len = e - b + 1;
    int start = send_cnt;
    in_region_begin = ADDR_W'(b);
    in_region_end   = ADDR_W'(e);
    mode_rev  = rev;
    if (e < b || len > DEPTH) begin
      exp_err += hold;
      cmd_ready = 1'b1;
      repeat (hold) @(negedge clk);
      cmd_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_after_err", 64'(busy), 64'(0));
    end else begin
      cur_region.delete();
      for (int i = 0; i < len; i++) begin
        exp_ptr_q.push_back(ADDR_W'(b + i));
        cur_region.push_back(mem[b + i]);
      end
      cur_rev = rev;
      exp_end_q.push_back(ADDR_W'(len - 1));
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      wait_send(start);
      chk("busy_serve", 64'(busy), 64'(1));
    end
  endtask

  task automatic rd(input int p);
    exp_rd_q.push_back(model_read(p));
    out_ptr  = ADDR_W'(p);
    out_r_en = 1'b1;
    @(negedge clk);
    out_r_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_hold(input int p);
    exp_rd_q.push_back(model_read(p));
    exp_rd_q.push_back(model_read(p));
    out_ptr  = ADDR_W'(p);
    out_r_en = 1'b1;
    repeat (4) @(negedge clk);
    out_r_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_cmd(input bit with_rd);
    cmd_done = 1'b1;
    out_r_en = with_rd;
    out_ptr  = '0;
    @(negedge clk);
    cmd_done = 1'b0;
    out_r_en = 1'b0;
    chk("busy_after_done", 64'(busy), 64'(0));
    @(negedge clk);
  endtask

  task automatic check_reset();
    chk("rst_in_ptr", 64'(in_ptr), 64'(0));
    chk("rst_in_r_en", 64'(in_r_en), 64'(0));
    chk("rst_cmd_send", 64'(cmd_send), 64'(0));
    chk("rst_out_region_end", 64'(out_region_end), 64'(0));
    chk("rst_out_done", 64'(out_done), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_err", 64'(cmd_err), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = DATA_W'(32'hA0 + i);

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    issue(16, 19, 1'b0, 1);
    for (int p = 0; p < 4; p++) rd(p);
    finish_cmd(1'b0);

    issue(16, 19, 1'b1, 1);
    rd(0); rd(3); rd(1); rd(2);
    rd_hold(2);
    finish_cmd(1'b0);

    issue(0, DEPTH - 1, 1'b0, 1);
    rd(0); rd(DEPTH - 1); rd(7);
    finish_cmd(1'b0);
    issue(0, DEPTH, 1'b0, 1);

    issue(6, 5, 1'b0, 1);
    issue(32, 32, 1'b0, 1);
    rd(0); rd(1);
    finish_cmd(1'b0);

    issue(16, 19, 1'b0, 1);
    rd(7);
    finish_cmd(1'b1);

    // Abort a fetch after two captured words.
    for (int i = 0; i < 4; i++) exp_ptr_q.push_back(ADDR_W'(64 + i));
    start = req_cnt;
    in_region_begin = 8'h40;
    in_region_end   = 8'h43;
    mode_rev  = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    for (int k = 0; k < 100 && req_cnt < start + 2; k++) @(negedge clk);
    chk("fetch_progress", 64'(req_cnt - start), 64'(2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    exp_ptr_q.delete();
    @(negedge clk);

    issue(48, 51, 1'b1, 1);
    for (int p = 0; p < 5; p++) rd(p);
    finish_cmd(1'b0);

    issue(0, 20, 1'b0, 3);

    noise = 1'b1;
    rand_lat = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int b = $urandom_range(10, 200);
      int e;
      if ($urandom_range(0, 7) == 0) e = b - 1 - int'($urandom_range(0, 3));
      else e = b + int'($urandom_range(1, DEPTH + 2)) - 1;
      issue(b, e, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
      if (e >= b && e - b + 1 <= DEPTH) begin
        int nr = $urandom_range(1, 6);
        for (int r = 0; r < nr; r++) rd($urandom_range(0, DEPTH + 3));
        finish_cmd(1'($urandom_range(0, 1)));
      end
    end
    noise = 1'b0;
    repeat (4) @(negedge clk);

    chk("leftover_ptr", 64'(exp_ptr_q.size()), 64'(0));
    chk("leftover_send", 64'(exp_end_q.size()), 64'(0));
    chk("leftover_read", 64'(exp_rd_q.size()), 64'(0));
    chk("leftover_err", 64'(exp_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
